pulse_train_gen: RTL and testbench

Parametrised BIST pulse-train generator, the next generation of the fixed 8-high/10-pulse controller. On a rising edge of `start` it emits `cfg_pulses` high pulses of `cfg_high` cycles each, separated by `cfg_low` low cycles, then flags completion. It sits between the BIST sequencer (start/config) and the circuit under test (`out`), with `running`/`bist_end` reported back as status. Config is run-time and latched per run, so one instance covers every test pattern.

---
 rtl/pulse_train_pkg.sv | 18 +
 rtl/counter_nb.sv | 42 ++++
 rtl/pulse_train_gen.sv | 178 +++++++++++++++++
 tb/tb_pulse_train_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_train_pkg : shared state encoding and defaults for pulse_train_gen   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package pulse_train_pkg;

  localparam int PULSE_TRAIN_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_H     = 2'd1,
    RUN_L     = 2'd2,
    COMPLETED = 2'd3
  } pulse_train_state_e;

endpackage : pulse_train_pkg
`default_nettype wire

// File: rtl/counter_nb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_nb : CNT_W-bit up-counter with synchronous clear and enable        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module counter_nb
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = PULSE_TRAIN_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Clear takes priority over enable so a wrap-to-zero and a count never collide.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : counter_nb
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_train_gen : run-time configurable BIST pulse-train generator         |
// | Optional abort port pair enabled by macro PULSE_TRAIN_ABORT_EN             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = PULSE_TRAIN_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [CNT_W-1:0] cfg_pulses,
  output logic             out,
  output logic             running,
  output logic             bist_end,
  output logic [CNT_W-1:0] pulse_cnt
`ifdef PULSE_TRAIN_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  function automatic logic [CNT_W-1:0] eff_cfg(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  pulse_train_state_e state_d, state_q;

  logic             p_start_d, p_start_q;
  logic             pos_start_d, pos_start_q;
  logic [CNT_W-1:0] high_d, high_q;
  logic [CNT_W-1:0] low_d, low_q;
  logic [CNT_W-1:0] pulses_d, pulses_q;
  logic             out_d, out_q;
  logic             running_d, running_q;
  logic             bist_end_d, bist_end_q;

  logic             phase_clr;
  logic             phase_en;
  logic             pulse_clr;
  logic             pulse_en;
  logic [CNT_W-1:0] phase_cnt;
  logic             abort_req;

`ifdef PULSE_TRAIN_ABORT_EN
  logic aborted_d, aborted_q;
  assign abort_req = abort;
  assign aborted   = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  counter_nb #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (phase_clr),
    .en    (phase_en),
    .count (phase_cnt)
  );

  counter_nb #(.CNT_W(CNT_W)) u_pulse_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (pulse_clr),
    .en    (pulse_en),
    .count (pulse_cnt)
  );

  always_comb begin
    state_d     = state_q;
    high_d      = high_q;
    low_d       = low_q;
    pulses_d    = pulses_q;
    p_start_d   = start;
    pos_start_d = start & ~p_start_q;
    phase_clr   = 1'b0;
    phase_en    = 1'b0;
    pulse_clr   = 1'b0;
    pulse_en    = 1'b0;
`ifdef PULSE_TRAIN_ABORT_EN
    aborted_d   = aborted_q;
`endif

    case (state_q)
      IDLE, COMPLETED: begin
        if (pos_start_q) begin
          state_d   = RUN_H;
          high_d    = eff_cfg(cfg_high);
          low_d     = eff_cfg(cfg_low);
          pulses_d  = eff_cfg(cfg_pulses);
          phase_clr = 1'b1;
          pulse_clr = 1'b1;
`ifdef PULSE_TRAIN_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      RUN_H: begin
        if (abort_req) begin
          state_d   = COMPLETED;
          phase_clr = 1'b1;
`ifdef PULSE_TRAIN_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (phase_cnt == high_q - CNT_W'(1)) begin
          pulse_en  = 1'b1;
          phase_clr = 1'b1;
          // Last pulse goes straight to COMPLETED: no trailing low phase.
          state_d   = (pulse_cnt + CNT_W'(1) == pulses_q) ? COMPLETED : RUN_L;
        end else begin
          phase_en = 1'b1;
        end
      end
      RUN_L: begin
        if (abort_req) begin
          state_d   = COMPLETED;
          phase_clr = 1'b1;
`ifdef PULSE_TRAIN_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (phase_cnt == low_q - CNT_W'(1)) begin
          phase_clr = 1'b1;
          state_d   = RUN_H;
        end else begin
          phase_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state decode, so they track state_q.
    out_d      = (state_d == RUN_H);
    running_d  = (state_d == RUN_H) || (state_d == RUN_L);
    bist_end_d = (state_d == COMPLETED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      p_start_q   <= 1'b1;
      pos_start_q <= 1'b0;
      high_q      <= CNT_W'(1);
      low_q       <= CNT_W'(1);
      pulses_q    <= CNT_W'(1);
      out_q       <= 1'b0;
      running_q   <= 1'b0;
      bist_end_q  <= 1'b0;
`ifdef PULSE_TRAIN_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      p_start_q   <= p_start_d;
      pos_start_q <= pos_start_d;
      high_q      <= high_d;
      low_q       <= low_d;
      pulses_q    <= pulses_d;
      out_q       <= out_d;
      running_q   <= running_d;
      bist_end_q  <= bist_end_d;
`ifdef PULSE_TRAIN_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign out      = out_q;
  assign running  = running_q;
  assign bist_end = bist_end_q;

endmodule : pulse_train_gen
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pulse_train_gen : scoreboard bench for pulse_train_gen                  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pulse_train_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] cfg_high;
  logic [7:0] cfg_low;
  logic [7:0] cfg_pulses;
  logic       out;
  logic       running;
  logic       bist_end;
  logic [7:0] pulse_cnt;
  logic       abort;
  logic       aborted;

  typedef struct packed {
    logic       o;
    logic       r;
    logic       e;
    logic [7:0] c;
    logic       a;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ab   = 1'b0;

  pulse_train_gen #(.CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_high   (cfg_high),
    .cfg_low    (cfg_low),
    .cfg_pulses (cfg_pulses),
    .out        (out),
    .running    (running),
    .bist_end   (bist_end),
    .pulse_cnt  (pulse_cnt)
`ifdef PULSE_TRAIN_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

`ifndef PULSE_TRAIN_ABORT_EN
  assign aborted = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic ab_bad;
      e = sb.pop_front();
      n_checks++;
`ifdef PULSE_TRAIN_ABORT_EN
      ab_bad = (aborted !== e.a);
`else
      ab_bad = 1'b0;
`endif
      if (out !== e.o || running !== e.r || bist_end !== e.e || pulse_cnt !== e.c || ab_bad) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got out=%b running=%b bist_end=%b pulse_cnt=%0d aborted=%b expected out=%b running=%b bist_end=%b pulse_cnt=%0d aborted=%b",
                 $time, out, running, bist_end, pulse_cnt, aborted, e.o, e.r, e.e, e.c, e.a);
      end
    end
  end

  task automatic step(input logic eo, input logic er, input logic ee, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    e.o = eo;
    e.r = er;
    e.e = ee;
    e.c = 8'(ec);
    e.a = exp_ab;
    sb.push_back(e);
  endtask

  task automatic run(input int h, input int l, input int p, input logic prev_end,
                     input int prev_cnt, input int mid_high, input logic toggle);
    int he, le, pe, c;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    pe = (p == 0) ? 1 : p;
    cfg_high   = 8'(h);
    cfg_low    = 8'(l);
    cfg_pulses = 8'(p);
    start      = 1'b1;
    step(1'b0, 1'b0, prev_end, prev_cnt);
    exp_ab = 1'b0;
    c = 0;
    for (int n = 0; n < pe; n++) begin
      for (int i = 0; i < he; i++) begin
        step(1'b1, 1'b1, 1'b0, n);
        c++;
        if (mid_high != 0 && c == 1) cfg_high = 8'(mid_high);
        if (toggle && c == 2) start = 1'b0;
        if (toggle && c == 4) start = 1'b1;
      end
      if (n < pe - 1) begin
        for (int j = 0; j < le; j++) begin
          step(1'b0, 1'b1, 1'b0, n + 1);
          c++;
          if (toggle && c == 2) start = 1'b0;
          if (toggle && c == 4) start = 1'b1;
        end
      end
    end
    step(1'b0, 1'b0, 1'b1, pe);
    start = 1'b0;
    step(1'b0, 1'b0, 1'b1, pe);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b1;
    abort      = 1'b0;
    cfg_high   = 8'd3;
    cfg_low    = 8'd2;
    cfg_pulses = 8'd4;

    // Reset values, then start held high across reset release must not run.
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 0);
    start = 1'b0;
    step(1'b0, 1'b0, 1'b0, 0);

    // H=3 L=2 P=4: 111 00 111 00 111 00 111, 18 running cycles, pulse_cnt 4.
    run(3, 2, 4, 1'b0, 0, 0, 1'b0);
    // Second rise from COMPLETED: 1 0 1, pulse_cnt 2.
    run(1, 1, 2, 1'b1, 4, 0, 1'b0);
    // All-zero config behaves as 1/1/1: one single-cycle pulse.
    run(0, 0, 0, 1'b1, 2, 0, 1'b0);
    // Mid-run config change (H 3->7) and start toggling inside the run.
    run(3, 2, 4, 1'b1, 1, 7, 1'b1);

    // Reset during the 5th running cycle.
    cfg_high = 8'd3; cfg_low = 8'd2; cfg_pulses = 8'd4;
    start = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4);
    repeat (3) step(1'b1, 1'b1, 1'b0, 0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 0);
    start = 1'b0;
    step(1'b0, 1'b0, 1'b0, 0);

`ifdef PULSE_TRAIN_ABORT_EN
    // Abort in running cycle 7 (second high cycle of pulse 2).
    start = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1);
    abort  = 1'b1;
    exp_ab = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1);
    abort = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1);
    start = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1);
    // Fresh start clears aborted.
    run(1, 1, 1, 1'b1, 1, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pulse_train_gen
`default_nettype wire
